// File: rtl/data_repeater_stream_if.sv
// Stream interface for data_repeater_stream.
//
// Carries the input word handshake (i_bits, i_n_rep, i_mode, i_valid, o_ready) and the output
// beat handshake (o_extended_bits, o_valid, i_ready, o_last). Signal names are from the block's
// point of view: i_* are driven towards the block, o_* are driven by it.
//
// Modports:
//   slave  - the repeater block itself
//   master - the environment (data source + downstream consumer)
//
// Optional: DATA_REPEATER_PARITY_EN adds o_parity (XOR of the current beat).
interface data_repeater_stream_if #(
  parameter int unsigned N_BITS_IN  = 3,
  parameter int unsigned N_BITS_OUT = 8,
  parameter int unsigned N_REPT_MAX = 5
);
  localparam int unsigned NB_REP = $clog2(N_REPT_MAX + 1);

  logic [N_BITS_IN-1:0]  i_bits;
  logic [NB_REP-1:0]     i_n_rep;
  logic                  i_mode;
  logic                  i_valid;
  logic                  o_ready;
  logic [N_BITS_OUT-1:0] o_extended_bits;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
`ifdef DATA_REPEATER_PARITY_EN
  logic                  o_parity;
`endif

  modport slave (
    input  i_bits,
    input  i_n_rep,
    input  i_mode,
    input  i_valid,
    input  i_ready,
    output o_ready,
    output o_extended_bits,
    output o_valid,
    output o_last
`ifdef DATA_REPEATER_PARITY_EN
    ,
    output o_parity
`endif
  );

  modport master (
    output i_bits,
    output i_n_rep,
    output i_mode,
    output i_valid,
    output i_ready,
    input  o_ready,
    input  o_extended_bits,
    input  o_valid,
    input  o_last
`ifdef DATA_REPEATER_PARITY_EN
    ,
    input  o_parity
`endif
  );

endinterface

// File: rtl/data_repeater_stream.sv
// Registered bit repeater with stream output.
//
// Accepts an N_BITS_IN word plus a repetition count, builds the expansion in which each input
// bit k is repeated rep times at E[k*rep +: rep], and emits it as N_BITS_OUT-wide beats:
//   mode 0 - a single beat E[N_BITS_OUT-1:0] (truncated or zero-padded), o_last=1
//   mode 1 - ceil(N_BITS_IN*rep / N_BITS_OUT) beats, o_last on the final one
// The repetition count is clamped to [1, N_REPT_MAX].
//
// Ports:
//   i_clock - clock, rising edge
//   i_reset - synchronous active-high reset
//   bus     - data_repeater_stream_if.slave (input word handshake + output beat handshake)
//
// Optional: define DATA_REPEATER_PARITY_EN to drive bus.o_parity = ^o_extended_bits.
module data_repeater_stream #(
  parameter int unsigned N_BITS_IN  = 3,
  parameter int unsigned N_BITS_OUT = 8,
  parameter int unsigned N_REPT_MAX = 5
) (
  input logic                   i_clock,
  input logic                   i_reset,
  data_repeater_stream_if.slave bus
);

  localparam int unsigned NB_REP   = $clog2(N_REPT_MAX + 1);
  localparam int unsigned ExpW     = N_BITS_IN * N_REPT_MAX;
  localparam int unsigned MaxBeats = (ExpW + N_BITS_OUT - 1) / N_BITS_OUT;
  // Expansion zero-extended to a whole number of beats so every beat slice is in range.
  localparam int unsigned PadW     = MaxBeats * N_BITS_OUT;
  localparam int unsigned CntW     = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e              state_q, state_d;
  logic [PadW-1:0]     shift_q, shift_d;
  logic [CntW-1:0]     beat_q, beat_d;
  logic [CntW-1:0]     last_q, last_d;

  logic                ready;
  logic                accept;
  logic                emit;
  logic                is_last;
  logic                xfer;
  logic [N_BITS_OUT-1:0] beat;

  int unsigned         rep_c;
  int unsigned         len_c;
  int unsigned         beats_c;
  logic [ExpW-1:0]     exp_c;
  logic [ExpW-1:0]     rep_mask;
  logic [N_BITS_IN-1:0] bits_sh;

  // Repetition clamp and beat count for the word currently offered on the input.
  always_comb begin
    rep_c = 32'(bus.i_n_rep);
    if (bus.i_n_rep == '0) begin
      rep_c = 1;
    end else if (bus.i_n_rep > NB_REP'(N_REPT_MAX)) begin
      rep_c = N_REPT_MAX;
    end
    len_c   = N_BITS_IN * rep_c;
    beats_c = bus.i_mode ? (len_c + N_BITS_OUT - 1) / N_BITS_OUT : 1;
    last_d  = CntW'(beats_c - 1);
  end

  // Expansion built MSB-first by shifting: each step appends rep copies of the next lower bit,
  // so bit k ends up at E[k*rep +: rep] and everything at or above L stays zero.
  always_comb begin
    exp_c    = '0;
    bits_sh  = '0;
    rep_mask = ~({ExpW{1'b1}} << rep_c);
    for (int k = N_BITS_IN - 1; k >= 0; k--) begin
      bits_sh = bus.i_bits >> k;
      exp_c   = exp_c << rep_c;
      if (bits_sh[0]) begin
        exp_c = exp_c | rep_mask;
      end
    end
  end

  // Handshake qualifiers.
  always_comb begin
    emit    = (state_q == StEmit);
    ready   = (state_q == StIdle) && !i_reset;
    accept  = ready && bus.i_valid;
    is_last = emit && (beat_q == last_q);
    xfer    = emit && bus.i_ready;
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (xfer && is_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: load on accept, shift one beat down on each non-final transfer,
  // clear after the final transfer so the output bus idles at zero.
  always_comb begin
    shift_d = shift_q;
    beat_d  = beat_q;
    if (accept) begin
      shift_d = PadW'(exp_c);
      beat_d  = '0;
    end else if (xfer) begin
      if (is_last) begin
        shift_d = '0;
        beat_d  = '0;
      end else begin
        shift_d = shift_q >> N_BITS_OUT;
        beat_d  = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      beat_q  <= '0;
      last_q  <= '0;
    end else begin
      shift_q <= shift_d;
      beat_q  <= beat_d;
      if (accept) begin
        last_q <= last_d;
      end
    end
  end

  // Outputs are decoded from registered state only; they cannot change under backpressure
  // because shift_q/beat_q only move on a transfer.
  always_comb begin
    beat                = emit ? shift_q[N_BITS_OUT-1:0] : '0;
    bus.o_ready         = ready;
    bus.o_valid         = emit;
    bus.o_last          = is_last;
    bus.o_extended_bits = beat;
`ifdef DATA_REPEATER_PARITY_EN
    bus.o_parity        = ^beat;
`endif
  end

endmodule

// File: tb/tb_data_repeater_stream.sv
// Scoreboard bench for data_repeater_stream: directed test-plan cases, mid-word reset and a
// randomized run with random downstream backpressure.
module tb_data_repeater_stream;

  localparam int unsigned NI = 3;
  localparam int unsigned NO = 8;
  localparam int unsigned NR = 5;
  localparam int unsigned NB = $clog2(NR + 1);

  typedef struct packed {
    logic [NO-1:0] data;
    logic          last;
    logic          par;
  } beat_t;

  logic clk;
  logic rst;

  data_repeater_stream_if #(.N_BITS_IN(NI), .N_BITS_OUT(NO), .N_REPT_MAX(NR)) bus ();

  data_repeater_stream #(
    .N_BITS_IN (NI),
    .N_BITS_OUT(NO),
    .N_REPT_MAX(NR)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  bit    bp_en = 1'b0;
  bit    ready_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: E[p] = bits[p / rep] for p < L, zero elsewhere; beats are NO-bit slices.
  task automatic push_word(input logic [NI-1:0] bits, input int nrep, input logic mode);
    int rep;
    int len;
    int nb;
    rep = (nrep == 0) ? 1 : ((nrep > int'(NR)) ? int'(NR) : nrep);
    len = NI * rep;
    nb  = mode ? (len + NO - 1) / NO : 1;
    for (int j = 0; j < nb; j++) begin
      beat_t         b;
      logic [NO-1:0] d;
      d = '0;
      for (int k = 0; k < int'(NO); k++) begin
        int p;
        p = j * NO + k;
        if (p < len) begin
          logic [NI-1:0] s;
          s = bits >> (p / rep);
          if (s[0]) d = d | (NO'(1) << k);
        end
      end
      b.data = d;
      b.last = (j == nb - 1);
      b.par  = ^d;
      exp_q.push_back(b);
    end
  endtask

  // Offers a word, waits for acceptance, and returns at the first output cycle's negedge.
  task automatic send(input logic [NI-1:0] bits, input int nrep, input logic mode);
    int t;
    @(posedge clk);
    #1;
    bus.i_bits  = bits;
    bus.i_n_rep = NB'(nrep);
    bus.i_mode  = mode;
    bus.i_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.o_ready) break;
      t++;
      if (t > 50) begin
        check("accept_timeout", 32'(t), 32'd0);
        bus.i_valid = 1'b0;
        return;
      end
    end
    push_word(bits, nrep, mode);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_bits  = NI'($urandom);
    bus.i_n_rep = NB'($urandom);
    bus.i_mode  = 1'($urandom);
    @(negedge clk);
    check("latency_valid", 32'(bus.o_valid), 32'd1);
  endtask

  task automatic check_beat(input string name, input logic [NO-1:0] d, input logic l);
    check({name, "_data"}, 32'(bus.o_extended_bits), 32'(d));
    check({name, "_last"}, 32'(bus.o_last), 32'(l));
    check({name, "_valid"}, 32'(bus.o_valid), 32'd1);
`ifdef DATA_REPEATER_PARITY_EN
    check({name, "_parity"}, 32'(bus.o_parity), 32'(^d));
`endif
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && bus.o_ready)) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        return;
      end
    end
  endtask

  // Downstream ready driver.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) bus.i_ready = ($urandom_range(0, 3) != 0);
      else       bus.i_ready = ready_force;
    end
  end

  // Monitor: pops expected beats on every transfer and checks hold-under-backpressure.
  logic          prev_valid;
  logic          prev_ready;
  logic          prev_last;
  logic [NO-1:0] prev_data;
  bit            have_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      check("ready_vs_valid", 32'(bus.o_ready), 32'(!bus.o_valid));
      if (have_prev && prev_valid && !prev_ready) begin
        check("hold_valid", 32'(bus.o_valid), 32'd1);
        check("hold_data", 32'(bus.o_extended_bits), 32'(prev_data));
        check("hold_last", 32'(bus.o_last), 32'(prev_last));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(bus.o_extended_bits), 32'hdead);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 32'(bus.o_extended_bits), 32'(e.data));
          check("beat_last", 32'(bus.o_last), 32'(e.last));
`ifdef DATA_REPEATER_PARITY_EN
          check("beat_parity", 32'(bus.o_parity), 32'(e.par));
`endif
        end
      end
      prev_valid = bus.o_valid;
      prev_ready = bus.i_ready;
      prev_data  = bus.o_extended_bits;
      prev_last  = bus.o_last;
      have_prev  = 1'b1;
    end
  end

  initial begin
    rst         = 1'b1;
    bus.i_bits  = '0;
    bus.i_n_rep = '0;
    bus.i_mode  = 1'b0;
    bus.i_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_data", 32'(bus.o_extended_bits), 32'd0);
    check("rst_last", 32'(bus.o_last), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.o_ready), 32'd1);

    // Mode 0 pad.
    send(3'b101, 2, 1'b0);
    check_beat("pad", 8'b00110011, 1'b1);
    wait_idle();
    check("pad_idle", 32'(bus.o_ready), 32'd1);

    // Mode 0 truncate.
    send(3'b101, 5, 1'b0);
    check_beat("trunc", 8'b00011111, 1'b1);
    wait_idle();

    // Clamp low and high.
    send(3'b101, 0, 1'b0);
    check_beat("clamp0", 8'b00000101, 1'b1);
    wait_idle();
    send(3'b101, 7, 1'b0);
    check_beat("clamp7", 8'b00011111, 1'b1);
    wait_idle();

    // Mode 1 chunked with 3 cycles of backpressure on beat 0.
    ready_force = 1'b0;
    send(3'b101, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_beat("bp_beat0", 8'b00011111, 1'b0);
      check("bp_ready", 32'(bus.o_ready), 32'd0);
      if (i < 2) @(negedge clk);
    end
    ready_force = 1'b1;
    @(negedge clk);
    check_beat("bp_beat0_xfer", 8'b00011111, 1'b0);
    @(negedge clk);
    check_beat("bp_beat1", 8'b01111100, 1'b1);
    wait_idle();

    // Reset mid-word: beat 1 must never appear.
    ready_force = 1'b0;
    send(3'b101, 5, 1'b1);
    check_beat("mid_beat0", 8'b00011111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_ready", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_valid", 32'(bus.o_valid), 32'd0);
    check("mid_data", 32'(bus.o_extended_bits), 32'd0);
    check("mid_last", 32'(bus.o_last), 32'd0);
    check("mid_ready", 32'(bus.o_ready), 32'd1);
    ready_force = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid_no_beat1", 32'(bus.o_valid), 32'd0);
    end

    // Randomized words with random backpressure.
    bp_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send(NI'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
    end
    bp_en       = 1'b0;
    ready_force = 1'b1;
    wait_idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
